// File: rtl/gf3m_pkg.sv
// Shared definitions for GF(3^97) shift-by-x datapaths: element geometry, digit
// encodings, the reduction tap positions of p(x) = x^97 + x^12 + 2, and the digit arithmetic.
package gf3m_pkg;

   localparam int M   = 97;
   localparam int W   = 2 * M;
   localparam int TAP = 12;
   localparam int TOP = M - 1;

   localparam logic [1:0] F3_0 = 2'b00;
   localparam logic [1:0] F3_1 = 2'b01;
   localparam logic [1:0] F3_2 = 2'b10;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Negation in GF(3) swaps 1 and 2, which in this encoding is a bit swap.
   function automatic logic [1:0] f3_neg(input logic [1:0] b);
      return {b[0], b[1]};
   endfunction

   function automatic logic [1:0] f3_add(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] r;
      case (a)
         F3_0:    r = b;
         F3_1:    r = (b == F3_0) ? F3_1 : (b == F3_1) ? F3_2 : F3_0;
         F3_2:    r = (b == F3_0) ? F3_2 : (b == F3_1) ? F3_0 : F3_1;
         default: r = F3_0;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] f3_sub(input logic [1:0] a, input logic [1:0] b);
      return f3_add(a, f3_neg(b));
   endfunction

endpackage

// File: rtl/gf3m_xstep.sv
// One reduction step of A by x^-1 (dir=0) or x^+1 (dir=1) modulo x^97 + x^12 + 2.
module gf3m_xstep
   import gf3m_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic         dir,
   output logic [W-1:0] c
);

   logic [W-1:0] dn;
   logic [W-1:0] up;

   // x^-1 = x^96 + x^11, so the digit shifted out at the bottom re-enters at 96 and 11.
   always_comb begin
      dn                   = {2'b00, a[W-1:2]};
      dn[2*TOP +: 2]       = a[1:0];
      dn[2*(TAP-1) +: 2]   = f3_add(a[2*TAP +: 2], a[1:0]);

      // x^97 = 2x^12 + 1, so the digit shifted out at the top re-enters at 0 and (negated) at 12.
      up                   = {a[W-3:0], 2'b00};
      up[1:0]              = a[2*TOP +: 2];
      up[2*TAP +: 2]       = f3_sub(a[2*(TAP-1) +: 2], a[2*TOP +: 2]);

      c = dir ? up : dn;
   end

endmodule

// File: rtl/gf3m_xpow_seq.sv
// Counted-loop sequencer computing C = A * x^(+/-k) mod p(x), one digit step per clock.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module gf3m_xpow_seq
   import gf3m_pkg::*;
#(
   parameter int KW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_a,
   input  logic          in_dir,
   input  logic [KW-1:0] in_k,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_c,
   output logic          busy
);

   state_t        state;
   logic [W-1:0]  acc;
   logic [KW-1:0] cnt;
   logic          dir_q;
   logic [W-1:0]  step_c;

   gf3m_xstep u_xstep (
      .a   (acc),
      .dir (dir_q),
      .c   (step_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         dir_q     <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  acc      <= in_a;
                  dir_q    <= in_dir;
                  cnt      <= in_k;
                  in_ready <= 1'b0;
                  if (in_k == '0) begin
                     state <= DONE;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               acc <= step_c;
               cnt <= cnt - KW'(1);
               if (cnt == KW'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               // out_valid rises one cycle after entering DONE; out_ready only counts once it is up.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_c = acc;

endmodule

// File: tb/tb_gf3m_xpow_seq.sv
// Bench for gf3m_xpow_seq: table of fixed and random vectors against a polynomial model,
// plus hand-written sequences for backpressure, round trip and mid-run reset.
module tb_gf3m_xpow_seq;
   import gf3m_pkg::*;

   localparam int KW    = 8;
   localparam int P_TAP = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic          in_dir = 1'b0;
   logic [KW-1:0] in_k = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_c;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   gf3m_xpow_seq #(.KW(KW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_dir    (in_dir),
      .in_k      (in_k),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic int mod3(input int x);
      return ((x % 3) + 3) % 3;
   endfunction

   // Polynomial model: multiply by x then subtract the leading term times p(x), or
   // add a0*p(x) so the constant term vanishes and divide exactly by x.
   function automatic logic [W-1:0] ref_xpow(input logic [W-1:0] a, input bit up, input int k);
      int d[M+1];
      int t;
      logic [W-1:0] r;
      for (int i = 0; i < M; i++) d[i] = int'(a[2*i +: 2]);
      d[M] = 0;
      for (int s = 0; s < k; s++) begin
         if (up) begin
            for (int i = M; i > 0; i--) d[i] = d[i-1];
            d[0] = 0;
            t = d[M];
            d[M] = 0;
            d[P_TAP] = mod3(d[P_TAP] - t);
            d[0] = mod3(d[0] - 2 * t);
         end else begin
            t = d[0];
            d[0] = mod3(d[0] + 2 * t);
            d[P_TAP] = mod3(d[P_TAP] + t);
            d[M] = mod3(d[M] + t);
            for (int i = 0; i < M; i++) d[i] = d[i+1];
            d[M] = 0;
         end
      end
      r = '0;
      for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(d[i]);
      return r;
   endfunction

   function automatic logic [W-1:0] rand_elem();
      logic [W-1:0] r;
      for (int i = 0; i < M; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
      return r;
   endfunction

   task automatic wait_in_ready(output bit ok);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      ok = in_ready;
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout: in_ready=0 required 1");
      end
   endtask

   task automatic accept(input logic [W-1:0] a, input bit dir, input int k);
      in_a = a; in_dir = dir; in_k = KW'(k); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out_valid(output int lat, output bit ok);
      lat = 0;
      while (!out_valid && lat < 400) begin
         @(posedge clk); #1; lat++;
      end
      ok = out_valid;
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL result_timeout: out_valid=0 required 1");
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input bit dir, input int k,
                         output logic [W-1:0] c, output int lat);
      bit ok;
      c = '0; lat = -1;
      wait_in_ready(ok);
      if (!ok) return;
      accept(a, dir, k);
      wait_out_valid(lat, ok);
      if (!ok) return;
      c = out_c;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [W-1:0] a;
      bit           dir;
      int           k;
      logic [W-1:0] exp;
      int           lat;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [W-1:0] one;
      logic [W-1:0] c, c2, a, exp_v;
      int lat;
      bit ok;

      one = 1;
      vecs[0] = '{one, 1'b0, 1, (one << 192) | (one << 22), 2};
      vecs[1] = '{(one << 192) | (one << 22), 1'b1, 1, one, 2};
      vecs[2] = '{one, 1'b1, 97, W'(26'h2000001), 98};
      vecs[3] = '{W'(2), 1'b0, 0, W'(2), 1};
      for (int i = 4; i < 12; i++) begin
         vecs[i].a   = rand_elem();
         vecs[i].dir = 1'($urandom_range(0, 1));
         vecs[i].k   = (i == 11) ? 255 : int'($urandom_range(0, 30));
         vecs[i].exp = ref_xpow(vecs[i].a, vecs[i].dir, vecs[i].k);
         vecs[i].lat = vecs[i].k + 1;
      end

      // Reset behaviour
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", W'(in_ready), W'(0));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out_c", out_c, '0);
      check("rst_busy", W'(busy), W'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", W'(in_ready), W'(1));

      // Table vectors
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].a, vecs[i].dir, vecs[i].k, c, lat);
         check($sformatf("vec%0d_out_c", i), c, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), W'(lat), W'(vecs[i].lat));
      end

      // Backpressure in DONE with a competing request
      a = rand_elem();
      exp_v = ref_xpow(a, 1'b1, 3);
      wait_in_ready(ok);
      if (ok) begin
         accept(a, 1'b1, 3);
         check("bp_busy_run", W'(busy), W'(1));
         check("bp_in_ready_run", W'(in_ready), W'(0));
         wait_out_valid(lat, ok);
         if (ok) begin
            for (int i = 0; i < 10; i++) begin
               in_valid = 1'b1; in_a = ~a; in_k = '0; in_dir = 1'b0;
               check($sformatf("bp_out_c_%0d", i), out_c, exp_v);
               check($sformatf("bp_in_ready_%0d", i), W'(in_ready), W'(0));
               check($sformatf("bp_out_valid_%0d", i), W'(out_valid), W'(1));
               @(posedge clk); #1;
            end
            in_valid = 1'b0;
            check("bp_final_out_c", out_c, exp_v);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("bp_released_out_valid", W'(out_valid), W'(0));
            check("bp_released_in_ready", W'(in_ready), W'(1));
            repeat (3) @(posedge clk);
            #1;
            check("bp_no_phantom_valid", W'(out_valid), W'(0));
            check("bp_no_phantom_busy", W'(busy), W'(0));
         end
      end

      // Illegal digits must not lock the sequencer up
      run_op({W{1'b1}}, 1'b0, 5, c, lat);
      check("illegal_latency", W'(lat), W'(6));

      // Round trip over 100 steps
      a = rand_elem();
      run_op(a, 1'b0, 100, c, lat);
      check("rt_down", c, ref_xpow(a, 1'b0, 100));
      run_op(c, 1'b1, 100, c2, lat);
      check("rt_back", c2, a);
      check("rt_latency", W'(lat), W'(101));

      // Reset in the middle of a run
      wait_in_ready(ok);
      if (ok) begin
         accept(a, 1'b0, 100);
         repeat (50) @(posedge clk);
         #1;
         check("mid_busy_before_rst", W'(busy), W'(1));
         rst_n = 1'b0;
         #1;
         check("mid_rst_out_valid", W'(out_valid), W'(0));
         check("mid_rst_out_c", out_c, '0);
         check("mid_rst_busy", W'(busy), W'(0));
         check("mid_rst_in_ready", W'(in_ready), W'(0));
         @(negedge clk) rst_n = 1'b1;
         @(posedge clk); #1;
         check("mid_rst_idle_ready", W'(in_ready), W'(1));
         check("mid_rst_idle_busy", W'(busy), W'(0));
         run_op(a, 1'b1, 2, c, lat);
         check("after_rst_out_c", c, ref_xpow(a, 1'b1, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
